// File: rtl/ysyx_23060240_core_ctrl_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding,
// default parameters and the watchdog-state classifier.
package ysyx_23060240_pkg;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_FETCH_REQ  = 4'd1;
    localparam logic [3:0] ST_FETCH_WAIT = 4'd2;
    localparam logic [3:0] ST_DECODE     = 4'd3;
    localparam logic [3:0] ST_EXEC       = 4'd4;
    localparam logic [3:0] ST_MEM_REQ    = 4'd5;
    localparam logic [3:0] ST_MEM_WAIT   = 4'd6;
    localparam logic [3:0] ST_WB         = 4'd7;
    localparam logic [3:0] ST_HALT       = 4'd8;
    localparam logic [3:0] ST_ERROR      = 4'd9;

    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int CNT_W_DEF          = 64;

    typedef enum logic [3:0] {
        S_IDLE       = ST_IDLE,
        S_FETCH_REQ  = ST_FETCH_REQ,
        S_FETCH_WAIT = ST_FETCH_WAIT,
        S_DECODE     = ST_DECODE,
        S_EXEC       = ST_EXEC,
        S_MEM_REQ    = ST_MEM_REQ,
        S_MEM_WAIT   = ST_MEM_WAIT,
        S_WB         = ST_WB,
        S_HALT       = ST_HALT,
        S_ERROR      = ST_ERROR
    } state_e;

    typedef struct packed {
        logic rd;
        logic wr;
        logic w;
        logic csr;
    } dec_flags_t;

    // States that wait on an external handshake and are guarded by the watchdog.
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH_REQ) || (s == S_FETCH_WAIT) ||
               (s == S_MEM_REQ)   || (s == S_MEM_WAIT);
    endfunction

endpackage

// File: rtl/ysyx_23060240_core_ctrl_if.sv
// IFU/LSU handshakes, decoder flags and commit strobes between the sequencer
// (master) and the rest of the core (slave).
interface ysyx_23060240_core_ctrl_if;

    logic ifu_req_valid;
    logic ifu_req_ready;
    logic ifu_resp_valid;
    logic ifu_resp_err;
    logic inst_latch_en;

    logic dec_mem_rd_en;
    logic dec_mem_wr_en;
    logic dec_w_en;
    logic dec_w_csr_en;
    logic dec_halt;

    logic lsu_req_valid;
    logic lsu_req_we;
    logic lsu_req_ready;
    logic lsu_resp_valid;
    logic lsu_resp_err;

    logic rf_we;
    logic csr_we;
    logic pc_we;

    modport master (
        output ifu_req_valid, inst_latch_en, lsu_req_valid, lsu_req_we,
               rf_we, csr_we, pc_we,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_err,
               dec_mem_rd_en, dec_mem_wr_en, dec_w_en, dec_w_csr_en, dec_halt,
               lsu_req_ready, lsu_resp_valid, lsu_resp_err
    );

    modport slave (
        input  ifu_req_valid, inst_latch_en, lsu_req_valid, lsu_req_we,
               rf_we, csr_we, pc_we,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_err,
               dec_mem_rd_en, dec_mem_wr_en, dec_w_en, dec_w_csr_en, dec_halt,
               lsu_req_ready, lsu_resp_valid, lsu_resp_err
    );

endinterface

// File: rtl/ysyx_23060240_core_ctrl_wdog.sv
// Handshake watchdog: counts cycles spent in a waiting state and flags expiry
// in the TIMEOUT_CYCLES-th cycle. TIMEOUT_CYCLES = 0 disables it.
module ysyx_23060240_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          hit;

    // cnt_q holds the cycles already spent, so the current cycle is number cnt_q+1.
    assign hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign expired = en_i && hit;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !hit) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ysyx_23060240_core_ctrl.sv
// Multi-cycle RV32 sequencer: fetch, decode, execute, optional memory access,
// writeback, with sticky halt/error, watchdog and mcycle/minstret counters.
module ysyx_23060240_core_ctrl
    import ysyx_23060240_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060240_core_ctrl_if.master     bus,
    output logic                          halted,
    output logic                          err,
    output logic [3:0]                    state_o,
    output logic [CNT_W-1:0]              mcycle,
    output logic [CNT_W-1:0]              minstret
);

    state_e           state_q, state_d;
    dec_flags_t       dec_q;
    logic             ifu_req_valid_q, lsu_req_valid_q, lsu_req_we_q;
    logic             rf_we_q, csr_we_q, pc_we_q;
    logic             halted_q, err_q;
    logic [CNT_W-1:0] mcycle_q, minstret_q;
    logic             wd_clr, wd_en, wd_expired;

    assign wd_en  = is_wait_state(state_q);
    assign wd_clr = (state_d != state_q) && is_wait_state(state_d);

    ysyx_23060240_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .expired (wd_expired)
    );

    // A completing handshake always beats an expiring watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       state_d = S_FETCH_REQ;
            S_FETCH_REQ: begin
                if (bus.ifu_req_ready)   state_d = S_FETCH_WAIT;
                else if (wd_expired)     state_d = S_ERROR;
            end
            S_FETCH_WAIT: begin
                if (bus.ifu_resp_valid)  state_d = bus.ifu_resp_err ? S_ERROR : S_DECODE;
                else if (wd_expired)     state_d = S_ERROR;
            end
            S_DECODE: begin
                if (bus.dec_halt)                               state_d = S_HALT;
                else if (bus.dec_mem_rd_en && bus.dec_mem_wr_en) state_d = S_ERROR;
                else                                            state_d = S_EXEC;
            end
            S_EXEC:       state_d = (dec_q.rd || dec_q.wr) ? S_MEM_REQ : S_WB;
            S_MEM_REQ: begin
                if (bus.lsu_req_ready)   state_d = S_MEM_WAIT;
                else if (wd_expired)     state_d = S_ERROR;
            end
            S_MEM_WAIT: begin
                if (bus.lsu_resp_valid)  state_d = bus.lsu_resp_err ? S_ERROR : S_WB;
                else if (wd_expired)     state_d = S_ERROR;
            end
            S_WB:         state_d = S_FETCH_REQ;
            S_HALT:       state_d = S_HALT;
            S_ERROR:      state_d = S_ERROR;
            default:      state_d = S_IDLE;
        endcase
    end

    // Moore strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            dec_q           <= '0;
            ifu_req_valid_q <= 1'b0;
            lsu_req_valid_q <= 1'b0;
            lsu_req_we_q    <= 1'b0;
            rf_we_q         <= 1'b0;
            csr_we_q        <= 1'b0;
            pc_we_q         <= 1'b0;
            halted_q        <= 1'b0;
            err_q           <= 1'b0;
            mcycle_q        <= '0;
            minstret_q      <= '0;
        end else begin
            state_q         <= state_d;
            ifu_req_valid_q <= (state_d == S_FETCH_REQ);
            lsu_req_valid_q <= (state_d == S_MEM_REQ);
            lsu_req_we_q    <= (state_d == S_MEM_REQ) && dec_q.wr;
            rf_we_q         <= (state_d == S_WB) && dec_q.w;
            csr_we_q        <= (state_d == S_WB) && dec_q.csr;
            pc_we_q         <= (state_d == S_WB);
            halted_q        <= (state_d == S_HALT);
            err_q           <= (state_d == S_ERROR);
            if (state_q == S_DECODE) begin
                dec_q <= '{rd:  bus.dec_mem_rd_en,
                           wr:  bus.dec_mem_wr_en,
                           w:   bus.dec_w_en,
                           csr: bus.dec_w_csr_en};
            end
            if (state_q != S_HALT && state_q != S_ERROR) begin
                mcycle_q <= mcycle_q + CNT_W'(1);
            end
            if (state_q == S_WB) begin
                minstret_q <= minstret_q + CNT_W'(1);
            end
        end
    end

    assign bus.ifu_req_valid = ifu_req_valid_q;
    assign bus.inst_latch_en = (state_q == S_FETCH_WAIT) && bus.ifu_resp_valid && !bus.ifu_resp_err;
    assign bus.lsu_req_valid = lsu_req_valid_q;
    assign bus.lsu_req_we    = lsu_req_we_q;
    assign bus.rf_we         = rf_we_q;
    assign bus.csr_we        = csr_we_q;
    assign bus.pc_we         = pc_we_q;
    assign halted            = halted_q;
    assign err               = err_q;
    assign state_o           = state_q;
    assign mcycle            = mcycle_q;
    assign minstret          = minstret_q;

endmodule
